// File: rtl/qtt_dma_sched_if.sv
// DMA port bundle between the readout sequencer and the time-tagger.
// The master drives a 4-phase request carrying memory select and chunk length.
// The slave returns an acknowledge that is already synchronised to the core clock.
interface qtt_dma_sched_if #(
  parameter int LEN_W = 20
);
  logic             req;
  logic [2:0]       mem_sel;
  logic [LEN_W-1:0] len;
  logic             ack;

  modport master (output req, output mem_sel, output len, input ack);
  modport slave  (input req, input mem_sel, input len, output ack);
endinterface

// File: rtl/qtt_dma_sched.sv
// Readout sequencer for the time-tagger DMA port.
// A single start command walks the enabled memories in order:
// TAG0..TAG3, then ARM, then SAMPLE.
// Each memory with a nonzero quantity is drained in capped chunks over a 4-phase req/ack handshake.
// Optional feature: define QTT_DMA_TIMEOUT_EN to add an ack timeout that ends the sequence with err[0].
// LEN_W must be at least as wide as TAG_AW, ARM_AW and SMP_AW.
module qtt_dma_sched #(
  parameter int TAG_AW = 16,
  parameter int ARM_AW = 10,
  parameter int SMP_AW = 18,
  parameter int LEN_W  = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [5:0]          cfg_mask_i,
  input  logic [LEN_W-1:0]    cfg_max_len_i,
  input  logic [15:0]         cfg_tout_i,
  input  logic [4*TAG_AW-1:0] tag_qty_i,
  input  logic [ARM_AW-1:0]   arm_qty_i,
  input  logic [SMP_AW-1:0]   smp_qty_i,
  qtt_dma_sched_if.master     dma,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          err_o,
  output logic [23:0]         xfer_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT_H,
    WAIT_L,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [5:0]       mask_q, mask_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       memSel_q, memSel_d;
  logic             req_q, req_d;
  logic [23:0]      xferCnt_q, xferCnt_d;
  logic             abortErr_q, abortErr_d;
  logic             abortFlag_q, abortFlag_d;
  logic [LEN_W-1:0] qtyExt;
  logic [LEN_W-1:0] chunkLen;
  logic [7:0]       maskExt;
  logic             toutHit;

`ifdef QTT_DMA_TIMEOUT_EN
  logic [15:0]      toutCnt_q, toutCnt_d;
  logic             toutErr_q, toutErr_d;
  logic [15:0]      toutCntNext;
`else
  logic             unusedTout;
`endif

  // Quantity of the memory currently pointed at by sel, zero-extended to the DMA length width.
  always_comb begin
    qtyExt = '0;
    case (sel_q)
      3'd0:    qtyExt = LEN_W'(tag_qty_i[0*TAG_AW +: TAG_AW]);
      3'd1:    qtyExt = LEN_W'(tag_qty_i[1*TAG_AW +: TAG_AW]);
      3'd2:    qtyExt = LEN_W'(tag_qty_i[2*TAG_AW +: TAG_AW]);
      3'd3:    qtyExt = LEN_W'(tag_qty_i[3*TAG_AW +: TAG_AW]);
      3'd4:    qtyExt = LEN_W'(arm_qty_i);
      3'd5:    qtyExt = LEN_W'(smp_qty_i);
      default: qtyExt = '0;
    endcase
  end

  // The chunk is whatever remains, capped by max_len unless the cap is zero.
  assign chunkLen = ((cfg_max_len_i == '0) || (remaining_q < cfg_max_len_i)) ?
                    remaining_q : cfg_max_len_i;

  // Padded mask so that sel values 6 and 7 index safely.
  assign maskExt = {2'b00, mask_q};

`ifdef QTT_DMA_TIMEOUT_EN
  // Timeout fires on the cycle the wait counter would reach the programmed limit.
  assign toutCntNext = toutCnt_q + 16'd1;
  assign toutHit     = (cfg_tout_i != 16'd0) && (toutCntNext == cfg_tout_i);
`else
  assign toutHit    = 1'b0;
  assign unusedTout = ^cfg_tout_i;
`endif

  // State register and all datapath registers; reset clears every output immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      mask_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      memSel_q    <= '0;
      req_q       <= 1'b0;
      xferCnt_q   <= '0;
      abortErr_q  <= 1'b0;
      abortFlag_q <= 1'b0;
`ifdef QTT_DMA_TIMEOUT_EN
      toutCnt_q   <= '0;
      toutErr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      memSel_q    <= memSel_d;
      req_q       <= req_d;
      xferCnt_q   <= xferCnt_d;
      abortErr_q  <= abortErr_d;
      abortFlag_q <= abortFlag_d;
`ifdef QTT_DMA_TIMEOUT_EN
      toutCnt_q   <= toutCnt_d;
      toutErr_q   <= toutErr_d;
`endif
    end
  end

  // Next-state logic: memory walk, chunking, handshake and abort/timeout handling.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    memSel_d    = memSel_q;
    req_d       = req_q;
    xferCnt_d   = xferCnt_q;
    abortErr_d  = abortErr_q;
    abortFlag_d = abortFlag_q;
`ifdef QTT_DMA_TIMEOUT_EN
    toutCnt_d   = toutCnt_q;
    toutErr_d   = toutErr_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          mask_d      = cfg_mask_i;
          xferCnt_d   = '0;
          abortErr_d  = 1'b0;
          abortFlag_d = 1'b0;
          sel_d       = '0;
`ifdef QTT_DMA_TIMEOUT_EN
          toutErr_d   = 1'b0;
`endif
          state_d     = SCAN;
        end
      end

      SCAN: begin
        if (abort_i) begin
          abortErr_d = 1'b1;
          state_d    = DONE;
        end else if (sel_q > 3'd5) begin
          state_d = DONE;
        end else if (!maskExt[sel_q]) begin
          sel_d = sel_q + 3'd1;
        end else if (qtyExt == '0) begin
          sel_d = sel_q + 3'd1;
        end else begin
          remaining_d = qtyExt;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (abort_i) begin
          abortErr_d = 1'b1;
          state_d    = DONE;
        end else begin
          len_d    = chunkLen;
          memSel_d = sel_q;
          req_d    = 1'b1;
`ifdef QTT_DMA_TIMEOUT_EN
          toutCnt_d = '0;
`endif
          state_d  = WAIT_H;
        end
      end

      WAIT_H: begin
        if (abort_i) abortFlag_d = 1'b1;
`ifdef QTT_DMA_TIMEOUT_EN
        toutCnt_d = toutCntNext;
`endif
        if (toutHit) begin
          req_d   = 1'b0;
`ifdef QTT_DMA_TIMEOUT_EN
          toutErr_d = 1'b1;
`endif
          state_d = DONE;
        end else if (dma.ack) begin
          req_d       = 1'b0;
          remaining_d = remaining_q - len_q;
          xferCnt_d   = xferCnt_q + 24'(len_q);
          state_d     = WAIT_L;
        end
      end

      WAIT_L: begin
        if (abort_i) abortFlag_d = 1'b1;
`ifdef QTT_DMA_TIMEOUT_EN
        toutCnt_d = toutCntNext;
`endif
        if (toutHit) begin
`ifdef QTT_DMA_TIMEOUT_EN
          toutErr_d = 1'b1;
`endif
          state_d = DONE;
        end else if (!dma.ack) begin
          if (abortFlag_q || abort_i) begin
            abortErr_d = 1'b1;
            state_d    = DONE;
          end else if (remaining_q != '0) begin
            state_d = REQ;
          end else begin
            sel_d   = sel_q + 3'd1;
            state_d = SCAN;
          end
        end
      end

      DONE: begin
        abortFlag_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign dma.req     = req_q;
  assign dma.mem_sel = memSel_q;
  assign dma.len     = len_q;

  assign busy_o     = (state_q == SCAN) || (state_q == REQ) ||
                      (state_q == WAIT_H) || (state_q == WAIT_L);
  assign done_o     = (state_q == DONE);
  assign xfer_cnt_o = xferCnt_q;
`ifdef QTT_DMA_TIMEOUT_EN
  assign err_o      = {abortErr_q, toutErr_q};
`else
  assign err_o      = {abortErr_q, 1'b0};
`endif

endmodule

// File: tb/tb_qtt_dma_sched.sv
// Directed testbench for qtt_dma_sched.
// A behavioural DMA responder answers requests with a programmable ack delay and hold time.
// A monitor records every request (select, length) for comparison against hand-computed lists.
module tb_qtt_dma_sched;
  localparam int TAG_AW = 16;
  localparam int ARM_AW = 10;
  localparam int SMP_AW = 18;
  localparam int LEN_W  = 20;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [5:0]          cfgMask = '0;
  logic [LEN_W-1:0]    cfgMaxLen = '0;
  logic [15:0]         cfgTout = '0;
  logic [4*TAG_AW-1:0] tagQty = '0;
  logic [ARM_AW-1:0]   armQty = '0;
  logic [SMP_AW-1:0]   smpQty = '0;
  logic                busy;
  logic                done;
  logic [1:0]          err;
  logic [23:0]         xferCnt;

  int errors = 0;
  int checks = 0;
  int ackDelay = 5;
  int ackHold = 2;
  bit ackEnable = 1'b1;
  int reqSel[$];
  int reqLen[$];
  logic prevReq = 1'b0;

  qtt_dma_sched_if #(.LEN_W(LEN_W)) ifc ();

  qtt_dma_sched #(
    .TAG_AW(TAG_AW), .ARM_AW(ARM_AW), .SMP_AW(SMP_AW), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .start_i(start),
    .abort_i(abort),
    .cfg_mask_i(cfgMask),
    .cfg_max_len_i(cfgMaxLen),
    .cfg_tout_i(cfgTout),
    .tag_qty_i(tagQty),
    .arm_qty_i(armQty),
    .smp_qty_i(smpQty),
    .dma(ifc.master),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .xfer_cnt_o(xferCnt)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse start with the given mask and chunk cap; request log is cleared first.
  task automatic applyStimulus(input logic [5:0] mask, input logic [LEN_W-1:0] maxLen);
    @(negedge clk);
    reqSel.delete();
    reqLen.delete();
    cfgMask   = mask;
    cfgMaxLen = maxLen;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Wait (bounded) for the done pulse and capture the status at that moment.
  task automatic waitDone(input string tag, output logic [1:0] errSeen,
                          output logic [23:0] xferSeen, output logic busySeen);
    bit seen = 1'b0;
    errSeen  = 'x;
    xferSeen = 'x;
    busySeen = 'x;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen     = 1'b1;
        errSeen  = err;
        xferSeen = xferCnt;
        busySeen = busy;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 32'(seen), 1);
  endtask

  // Bounded wait for dma req to be high.
  task automatic waitReq(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_reqRise"}, 32'(seen), 1);
  endtask

  // Compare one logged request against its expected select and length.
  task automatic checkReq(input string tag, input int idx, input int expSel, input int expLen);
    bit present = (idx < reqSel.size());
    checkOutput($sformatf("%s_req%0d_present", tag, idx), 32'(present), 1);
    if (present) begin
      checkOutput($sformatf("%s_req%0d_sel", tag, idx), 32'(reqSel[idx]), 32'(expSel));
      checkOutput($sformatf("%s_req%0d_len", tag, idx), 32'(reqLen[idx]), 32'(expLen));
    end
  endtask

  // DMA responder: ack after ackDelay cycles of req, drop ack ackHold cycles after req falls.
  initial begin
    ifc.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ackEnable && ifc.req === 1'b1 && !ifc.ack) begin
        repeat (ackDelay - 1) @(negedge clk);
        ifc.ack = 1'b1;
        while (ifc.req === 1'b1) @(negedge clk);
        repeat (ackHold - 1) @(negedge clk);
        ifc.ack = 1'b0;
      end
    end
  end

  // Request monitor: logs each rising req and checks for stale ack and zero length.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ifc.req === 1'b1 && prevReq !== 1'b1) begin
        reqSel.push_back(int'(ifc.mem_sel));
        reqLen.push_back(int'(ifc.len));
        checkOutput("staleAck", 32'(ifc.ack), 0);
        checkOutput("lenNonZero", 32'(ifc.len != '0), 1);
      end
      prevReq = ifc.req;
    end
  end

  // Global safety net in case a bounded wait is bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [1:0]  errSeen;
    logic [23:0] xferSeen;
    logic        busySeen;
    int          hiCount;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_req", 32'(ifc.req), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_xfer", 32'(xferCnt), 0);
    checkOutput("rst_len", 32'(ifc.len), 0);
    checkOutput("rst_sel", 32'(ifc.mem_sel), 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: single memory, no cap, latency");
    tagQty = {16'd0, 16'd0, 16'd0, 16'd100};
    ackDelay = 5;
    reqSel.delete();
    reqLen.delete();
    cfgMask = 6'b000001;
    cfgMaxLen = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t1_busyN1", 32'(busy), 1);
    checkOutput("t1_reqN1", 32'(ifc.req), 0);
    @(negedge clk);
    checkOutput("t1_reqN2", 32'(ifc.req), 0);
    @(negedge clk);
    checkOutput("t1_reqN3", 32'(ifc.req), 1);
    waitDone("t1", errSeen, xferSeen, busySeen);
    checkOutput("t1_busyAtDone", 32'(busySeen), 0);
    checkOutput("t1_err", 32'(errSeen), 0);
    checkOutput("t1_xfer", 32'(xferSeen), 100);
    checkOutput("t1_reqCount", 32'(reqSel.size()), 1);
    checkReq("t1", 0, 0, 100);
    @(negedge clk);
    checkOutput("t1_donePulse", 32'(done), 0);
    checkOutput("t1_lenHold", 32'(ifc.len), 100);
    checkOutput("t1_selHold", 32'(ifc.mem_sel), 0);

    $display("[TB] test 2: chunked ARM readout");
    armQty = 10'd250;
    applyStimulus(6'b010000, 20'd64);
    waitDone("t2", errSeen, xferSeen, busySeen);
    checkOutput("t2_err", 32'(errSeen), 0);
    checkOutput("t2_xfer", 32'(xferSeen), 250);
    checkOutput("t2_reqCount", 32'(reqSel.size()), 4);
    checkReq("t2", 0, 4, 64);
    checkReq("t2", 1, 4, 64);
    checkReq("t2", 2, 4, 64);
    checkReq("t2", 3, 4, 58);

    $display("[TB] test 3: mask walk with zero quantity");
    tagQty = {16'd7, 16'd55, 16'd0, 16'd3};
    armQty = 10'd33;
    smpQty = 18'd9;
    applyStimulus(6'b101011, '0);
    waitDone("t3", errSeen, xferSeen, busySeen);
    checkOutput("t3_err", 32'(errSeen), 0);
    checkOutput("t3_xfer", 32'(xferSeen), 19);
    checkOutput("t3_reqCount", 32'(reqSel.size()), 3);
    checkReq("t3", 0, 0, 3);
    checkReq("t3", 1, 3, 7);
    checkReq("t3", 2, 5, 9);

    $display("[TB] test 4: abort mid-handshake");
    tagQty = {16'd0, 16'd0, 16'd0, 16'd100};
    ackDelay = 8;
    applyStimulus(6'b000001, 20'd64);
    waitReq("t4");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t4_reqHeld", 32'(ifc.req), 1);
    waitDone("t4", errSeen, xferSeen, busySeen);
    checkOutput("t4_err", 32'(errSeen), 2);
    checkOutput("t4_xfer", 32'(xferSeen), 64);
    checkOutput("t4_reqCount", 32'(reqSel.size()), 1);
    checkReq("t4", 0, 0, 64);
    ackDelay = 5;
    repeat (5) @(negedge clk);

`ifdef QTT_DMA_TIMEOUT_EN
    $display("[TB] test 5: ack timeout");
    ackEnable = 1'b0;
    cfgTout = 16'd20;
    applyStimulus(6'b000001, '0);
    waitReq("t5");
    hiCount = 0;
    while (ifc.req && hiCount < 100) begin
      hiCount++;
      @(negedge clk);
    end
    checkOutput("t5_reqHighCycles", 32'(hiCount), 20);
    waitDone("t5", errSeen, xferSeen, busySeen);
    checkOutput("t5_err", 32'(errSeen), 1);
    checkOutput("t5_xfer", 32'(xferSeen), 0);
    ackEnable = 1'b1;
    cfgTout = '0;
    repeat (3) @(negedge clk);
`endif

    $display("[TB] test 6a: reset in WAIT_H");
    applyStimulus(6'b000001, 20'd64);
    for (int i = 0; i < 200; i++) begin
      if (reqSel.size() >= 2) break;
      @(negedge clk);
    end
    checkOutput("t6a_reqCount", 32'(reqSel.size()), 2);
    checkOutput("t6a_preXfer", 32'(xferCnt), 64);
    checkOutput("t6a_preLen", 32'(ifc.len), 36);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6a_req", 32'(ifc.req), 0);
    checkOutput("t6a_busy", 32'(busy), 0);
    checkOutput("t6a_done", 32'(done), 0);
    checkOutput("t6a_err", 32'(err), 0);
    checkOutput("t6a_xfer", 32'(xferCnt), 0);
    checkOutput("t6a_len", 32'(ifc.len), 0);
    checkOutput("t6a_sel", 32'(ifc.mem_sel), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t6a_idleBusy", 32'(busy), 0);
    checkOutput("t6a_idleReq", 32'(ifc.req), 0);

    $display("[TB] test 6b: start with abort in IDLE");
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("t6b_busy1", 32'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("t6b_busy4", 32'(busy), 0);
    checkOutput("t6b_req4", 32'(ifc.req), 0);

    $display("[TB] test 6c: start while busy");
    tagQty = {16'd4, 16'd5, 16'd6, 16'd100};
    applyStimulus(6'b000001, '0);
    waitReq("t6c");
    cfgMask = 6'b111111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("t6c", errSeen, xferSeen, busySeen);
    checkOutput("t6c_err", 32'(errSeen), 0);
    checkOutput("t6c_xfer", 32'(xferSeen), 100);
    checkOutput("t6c_reqCount", 32'(reqSel.size()), 1);
    checkReq("t6c", 0, 0, 100);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qtt_dma_sched.md
Name: qtt_dma_sched

Overview:
- Readout sequencer for the time-tagger DMA port.
- On one start command it walks the enabled memories in order: tag FIFOs for ADC0..3, then the ARM FIFO, then the SAMPLE FIFO.
- It issues one or more chunked DMA requests per memory, using a 4-phase req/ack handshake, until each selected memory's quantity is drained.
- It sits between the AXI register block (start, mask, configuration, status) and the tagger's dma_req / dma_mem_sel / dma_len / dma_ack inputs.

Parameters:
- TAG_AW, 16: tag FIFO quantity width.
- ARM_AW, 10: ARM FIFO quantity width.
- SMP_AW, 18: SAMPLE FIFO quantity width.
- LEN_W, 20: DMA length width (fixed requirement: LEN_W >= TAG_AW, ARM_AW, SMP_AW).

Ports:
- clk_i, in, 1: core clock.
- rst_ni, in, 1: asynchronous active-low reset.
- start_i, in, 1: one-cycle start pulse.
- abort_i, in, 1: one-cycle abort pulse.
- cfg_mask_i, in, 6: memory enables; bits 0-3 = TAG0-3, bit 4 = ARM, bit 5 = SMP.
- cfg_max_len_i, in, LEN_W: chunk size cap; 0 = no cap.
- cfg_tout_i, in, 16: ack timeout in cycles; 0 = disabled (used only with the optional feature).
- tag_qty_i, in, 4*TAG_AW: tag FIFO quantities, TAG0 in the LSBs.
- arm_qty_i, in, ARM_AW: ARM FIFO quantity.
- smp_qty_i, in, SMP_AW: SAMPLE FIFO quantity.
- dma_req_o, out, 1: DMA request (4-phase handshake).
- dma_mem_sel_o, out, 3: memory select; 0-3 = TAG0-3, 4 = ARM, 5 = SMP.
- dma_len_o, out, LEN_W: length of the current chunk.
- dma_ack_i, in, 1: DMA acknowledge, already synchronised to clk_i.
- busy_o, out, 1: high from the cycle after an accepted start until DONE.
- done_o, out, 1: one-cycle pulse at end of sequence.
- err_o, out, 2: bit0 = timeout, bit1 = aborted; sticky until the next accepted start.
- xfer_cnt_o, out, 24: total words requested in this sequence.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, sel = 0, remaining = 0, abort flag cleared.
- States: IDLE, SCAN, REQ, WAIT_H, WAIT_L, DONE.
- IDLE:
  - start_i=1 and abort_i=0: latch cfg_mask_i, clear xfer_cnt and err, sel = 0, go to SCAN.
  - start_i and abort_i together: ignored.
  - start_i in any other state: ignored.
- SCAN:
  - sel > 5: go to DONE.
  - mask[sel] = 0: sel++, stay in SCAN (one cycle per memory).
  - Otherwise: snapshot that memory's qty, zero-extended to LEN_W, into remaining. qty = 0 gives sel++; else go to REQ.
  - Qty is sampled per memory at SCAN time, not at start.
- REQ:
  - dma_len_o = min(remaining, cfg_max_len_i), or remaining if cfg_max_len_i = 0.
  - dma_mem_sel_o = sel, dma_req_o = 1 (registered), go to WAIT_H.
  - Latency: start sampled in cycle N, with TAG0 enabled and nonzero, gives dma_req_o high from N+3.
- WAIT_H:
  - Hold req, sel and len stable until dma_ack_i = 1.
  - Then: req = 0, remaining -= len, xfer_cnt += len, go to WAIT_L.
- WAIT_L:
  - Wait for dma_ack_i = 0.
  - Abort flag set: go to DONE with err[1] = 1.
  - Else remaining != 0: go to REQ (next chunk of the same memory).
  - Else: sel++, go to SCAN.
- Abort:
  - abort_i in SCAN or REQ: go to DONE with err[1] = 1 next cycle. If in REQ, no request is issued.
  - abort_i in WAIT_H/WAIT_L: latch the abort flag. The handshake completes first (req is never dropped before ack), then DONE.
- DONE: done_o = 1 for one cycle, busy_o = 0 in the same cycle, return to IDLE. dma_len_o and dma_mem_sel_o hold their last values.
- Width: xfer_cnt has no wrap; 6*(2^LEN_W - 1) fits in 24 bits for LEN_W = 20. dma_len_o is never 0 while dma_req_o = 1.
- ack already high on entry to WAIT_H (stale ack): treated as the ack. The bench checks that this never happens in the legal flow.

Optional Feature:
- Macro: QTT_DMA_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_H and counts in WAIT_H and WAIT_L.
  - If cfg_tout_i != 0 and the counter reaches cfg_tout_i: dma_req_o = 0, err[0] = 1, go to DONE, skipping the remaining memories.
- Not defined: no counter, cfg_tout_i is unused, err[0] is tied to 0, and the scheduler waits indefinitely.

Test Plan:
1. Single memory, no cap:
   - Stimulus: mask=6'b000001, tag0 qty=100, max_len=0, ack after 5 cycles, drop after 2.
   - Required: one req with sel=0, len=100; xfer_cnt=100; done pulse; err=0.
2. Chunked readout:
   - Stimulus: mask=6'b010000, arm qty=250, max_len=64.
   - Required: four reqs with sel=4, len 64, 64, 64, 58; xfer_cnt=250.
3. Mask walk with a zero quantity:
   - Stimulus: mask=6'b101011, qty TAG0=3, TAG1=0, TAG3=7, SMP=9.
   - Required: reqs with sel 0 (len 3), 3 (len 7), 5 (len 9); sel 1 is skipped; xfer_cnt=19.
4. Abort mid-handshake:
   - Stimulus: abort_i in WAIT_H of a 2-chunk transfer.
   - Required: req held until ack; no second chunk issued; done with err=2'b10.
5. Timeout (QTT_DMA_TIMEOUT_EN defined):
   - Stimulus: tout=20, ack never asserted.
   - Required: req drops 20 cycles after assertion; err=2'b01; done pulse.
6. Reset and start corner cases:
   - Reset in WAIT_H gives all outputs 0 on the same edge, then IDLE.
   - start plus abort together in IDLE gives no busy.
   - start while busy is ignored and xfer_cnt is unchanged.
